// File: rtl/full_subtractor_core.sv
// full_subtractor_core: ripple-borrow subtractor D = A - B - Bin with combinational and 1-cycle registered outputs
// Ports: clk/rst (async active-high, clears D_q/Bout_q only); A minuend, B subtrahend, Bin borrow-in;
//        D/Bout combinational difference and borrow-out; D_q/Bout_q registered copies.
module full_subtractor_core #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic [WIDTH-1:0] D_q,
  output logic             Bout_q
);
  logic [WIDTH:0]   w_b;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  assign w_b[0] = Bin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign D[i]     = A[i] ^ B[i] ^ w_b[i];
    assign w_b[i+1] = (~A[i] & B[i]) | (~A[i] & w_b[i]) | (B[i] & w_b[i]);
  end
  assign Bout = w_b[WIDTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_d    <= '0;
      r_bout <= 1'b0;
    end else begin
      r_d    <= D;
      r_bout <= Bout;
    end
  assign D_q    = r_d;
  assign Bout_q = r_bout;
endmodule

// File: tb/tb_full_subtractor_core.sv
// tb_full_subtractor_core: directed and random checks of 1-bit and 8-bit subtractor instances
module tb_full_subtractor_core;
  logic clk = 1'b0;
  logic rst;
  logic a1, b1, bin1, d1, bo1, dq1, boq1;
  logic [7:0] a8, b8, d8, dq8;
  logic bin8, bo8, boq8;
  int checks = 0;
  int errors = 0;
  logic [1:0] tt [8];
  logic [8:0] exp9;
  always #5 clk = ~clk;
  full_subtractor_core #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .Bin(bin1),
    .D(d1), .Bout(bo1), .D_q(dq1), .Bout_q(boq1)
  );
  full_subtractor_core #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Bin(bin8),
    .D(d8), .Bout(bo8), .D_q(dq8), .Bout_q(boq8)
  );
  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    #1;
    chk("reset_q1", {7'd0, dq1, boq1}, 9'd0);
    chk("reset_q8", {boq8, dq8}, 9'd0);
    chk("rst_comb1", {7'd0, d1, bo1}, 9'b11);
    @(posedge clk); #1;
    chk("rst_hold_q1", {7'd0, dq1, boq1}, 9'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("first_capture1", {7'd0, dq1, boq1}, 9'b11);
    for (int i = 0; i < 8; i++) begin
      {a1, b1, bin1} = 3'(i);
      #10;
      chk($sformatf("tt_%0d", i), {7'd0, d1, bo1}, {7'd0, tt[i]});
    end
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; #1;
    chk("w8_5m3", {bo8, d8}, {1'b0, 8'h02});
    a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1; #1;
    chk("w8_underflow", {bo8, d8}, {1'b1, 8'h00});
    a8 = 8'h5A; b8 = 8'h5A; bin8 = 1'b0; #1;
    chk("w8_equal", {bo8, d8}, {1'b0, 8'h00});
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; #1;
    chk("w8_allones", {bo8, d8}, {1'b0, 8'hFF});
    a8 = 8'h80; b8 = 8'h00; bin8 = 1'b1; #1;
    chk("w8_ripple", {bo8, d8}, {1'b0, 8'h7F});
    @(posedge clk); #1;
    chk("w8_ripple_q", {boq8, dq8}, {1'b0, 8'h7F});
    #2 rst = 1'b1; #1;
    chk("async_rst_q8", {boq8, dq8}, 9'd0);
    chk("async_rst_comb8", {bo8, d8}, {1'b0, 8'h7F});
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_q8", {boq8, dq8}, {1'b0, 8'h7F});
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      exp9 = {1'b0, a8} - {1'b0, b8} - {8'd0, bin8};
      #1;
      chk("rand_comb", {bo8, d8}, exp9);
      @(posedge clk); #1;
      chk("rand_q", {boq8, dq8}, exp9);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
